// File: rtl/net_tdm_ingress_pkg.sv
// Shared definitions for the TDM ingress stage: domain encoding, message widths
// and a width helper used to size queue pointers and the slot counter.
package net_tdm_ingress_pkg;

  localparam int VC_NET_MSG_NBITS  = 44;
  localparam int VC_NET_MSG_DNBITS = 32;

  typedef enum logic {
    DOMAIN_D1 = 1'b0,
    DOMAIN_D2 = 1'b1
  } domain_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/net_tdm_ingress_queue.sv
// Per-domain FIFO: wrap-bit pointers, no bypass, no refill through a full queue.
// enq_rdy rises on the first edge after reset and depends only on registered state.
module net_tdm_ingress_queue
  import net_tdm_ingress_pkg::*;
#(
  parameter int p_width       = 76,
  parameter int p_num_entries = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_width-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_width-1:0] deq_msg
);

  localparam int AW = clog2(p_num_entries);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               open_q;
  logic               full;
  logic               empty;
  logic               enq_fire;
  logic               deq_fire;
  logic [p_width-1:0] mem [p_num_entries];

  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty    = (wr_ptr == rd_ptr);
  assign enq_rdy  = open_q && !full;
  assign deq_val  = !empty;
  assign deq_msg  = mem[rd_ptr[AW-1:0]];
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      open_q <= 1'b0;
    end else begin
      open_q <= 1'b1;
      if (enq_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (deq_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only observed behind valid pointers.
  always_ff @(posedge clk) begin
    if (enq_fire) mem[wr_ptr[AW-1:0]] <= enq_msg;
  end

endmodule

// File: rtl/net_tdm_ingress.sv
// Two-domain ingress stage: fixed time-division slots select which queue may
// drive the ring terminal port, so neither domain's timing depends on the other.
module net_tdm_ingress
  import net_tdm_ingress_pkg::*;
#(
  parameter int p_msg_cnbits  = VC_NET_MSG_NBITS,
  parameter int p_msg_dnbits  = VC_NET_MSG_DNBITS,
  parameter int p_num_entries = 2,
  parameter int p_slot_cycles = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in0_val,
  output logic                    in0_rdy,
  input  logic [p_msg_cnbits-1:0] in0_msg_control,
  input  logic [p_msg_dnbits-1:0] in0_msg_data,
  input  logic                    in1_val,
  output logic                    in1_rdy,
  input  logic [p_msg_cnbits-1:0] in1_msg_control,
  input  logic [p_msg_dnbits-1:0] in1_msg_data,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [p_msg_cnbits-1:0] out_msg_control,
  output logic [p_msg_dnbits-1:0] out_msg_data,
  output logic                    out_domain
);

  localparam int MW = p_msg_cnbits + p_msg_dnbits;
  localparam int SW = (p_slot_cycles > 1) ? clog2(p_slot_cycles) : 1;

  logic [SW-1:0] slot_cnt;
  domain_e       active;
  logic          q0_deq_val;
  logic          q1_deq_val;
  logic [MW-1:0] q0_msg;
  logic [MW-1:0] q1_msg;
  logic [MW-1:0] head;

  net_tdm_ingress_queue #(
    .p_width       (MW),
    .p_num_entries (p_num_entries)
  ) u_q0 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (in0_val),
    .enq_rdy (in0_rdy),
    .enq_msg ({in0_msg_control, in0_msg_data}),
    .deq_val (q0_deq_val),
    .deq_rdy (out_rdy && (active == DOMAIN_D1)),
    .deq_msg (q0_msg)
  );

  net_tdm_ingress_queue #(
    .p_width       (MW),
    .p_num_entries (p_num_entries)
  ) u_q1 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (in1_val),
    .enq_rdy (in1_rdy),
    .enq_msg ({in1_msg_control, in1_msg_data}),
    .deq_val (q1_deq_val),
    .deq_rdy (out_rdy && (active == DOMAIN_D2)),
    .deq_msg (q1_msg)
  );

  // Slot timing is a pure function of cycles since reset; queue state never feeds it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
      active   <= DOMAIN_D1;
    end else if (slot_cnt == SW'(p_slot_cycles - 1)) begin
      slot_cnt <= '0;
      active   <= (active == DOMAIN_D1) ? DOMAIN_D2 : DOMAIN_D1;
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  always_comb begin
    out_val = q0_deq_val;
    head    = q0_msg;
    if (active == DOMAIN_D2) begin
      out_val = q1_deq_val;
      head    = q1_msg;
    end
  end

  assign out_msg_control = head[MW-1:p_msg_dnbits];
  assign out_msg_data    = head[p_msg_dnbits-1:0];
  assign out_domain      = active;

endmodule

// File: tb/tb_net_tdm_ingress.sv
// Bench for net_tdm_ingress: directed scenarios then random traffic, checked
// against a queue-based model of the slot schedule.
module tb_net_tdm_ingress;

  localparam int CN = 44;
  localparam int DN = 32;
  localparam int N  = 2;
  localparam int S  = 4;
  localparam int MW = CN + DN;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in0_val, in0_rdy, in1_val, in1_rdy;
  logic [CN-1:0] in0_msg_control, in1_msg_control, out_msg_control;
  logic [DN-1:0] in0_msg_data, in1_msg_data, out_msg_data;
  logic          out_val, out_rdy, out_domain;

  net_tdm_ingress #(
    .p_msg_cnbits  (CN),
    .p_msg_dnbits  (DN),
    .p_num_entries (N),
    .p_slot_cycles (S)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in0_val         (in0_val),
    .in0_rdy         (in0_rdy),
    .in0_msg_control (in0_msg_control),
    .in0_msg_data    (in0_msg_data),
    .in1_val         (in1_val),
    .in1_rdy         (in1_rdy),
    .in1_msg_control (in1_msg_control),
    .in1_msg_data    (in1_msg_data),
    .out_val         (out_val),
    .out_rdy         (out_rdy),
    .out_msg_control (out_msg_control),
    .out_msg_data    (out_msg_data),
    .out_domain      (out_domain)
  );

  // scoreboard: per-domain expected queues plus time since reset release
  logic [MW-1:0] exp_q0[$];
  logic [MW-1:0] exp_q1[$];
  int            n_edges;
  bit            started;
  int            vectors = 0;
  int            miscompares = 0;

  function automatic logic model_act();
    return ((n_edges / S) % 2) == 1;
  endfunction

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n_edges);
    end
  endtask

  task automatic check_all();
    logic          act;
    logic          ev;
    logic [MW-1:0] hd;
    act = model_act();
    ev  = act ? (exp_q1.size() > 0) : (exp_q0.size() > 0);
    chk("out_val", MW'(out_val), MW'(ev));
    chk("out_domain", MW'(out_domain), MW'(act));
    chk("in0_rdy", MW'(in0_rdy), MW'(started && exp_q0.size() < N));
    chk("in1_rdy", MW'(in1_rdy), MW'(started && exp_q1.size() < N));
    if (ev) begin
      hd = act ? exp_q1[0] : exp_q0[0];
      chk("out_msg_control", MW'(out_msg_control), MW'(hd[MW-1:DN]));
      chk("out_msg_data", MW'(out_msg_data), MW'(hd[DN-1:0]));
    end
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    n_edges = 0;
    started = 1'b0;
  endtask

  // driver: one clock edge, model update from pre-edge state, check on negedge
  task automatic tick();
    logic act, ov, r0, r1;
    @(posedge clk);
    act = model_act();
    ov  = act ? (exp_q1.size() > 0) : (exp_q0.size() > 0);
    r0  = started && exp_q0.size() < N;
    r1  = started && exp_q1.size() < N;
    if (ov && out_rdy) begin
      if (act) void'(exp_q1.pop_front());
      else     void'(exp_q0.pop_front());
    end
    if (in0_val && r0) exp_q0.push_back({in0_msg_control, in0_msg_data});
    if (in1_val && r1) exp_q1.push_back({in1_msg_control, in1_msg_data});
    n_edges++;
    started = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in0_val = 1'b0;
    in1_val = 1'b0;
    out_rdy = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_all();
    tick();
  endtask

  task automatic rand_payloads();
    in0_msg_control = CN'({$urandom(), $urandom()});
    in0_msg_data    = $urandom();
    in1_msg_control = CN'({$urandom(), $urandom()});
    in1_msg_data    = $urandom();
  endtask

  logic [MW-1:0] seen;

  initial begin
    reset = 1'b0;
    in0_val = 1'b1;
    in1_val = 1'b0;
    out_rdy = 1'b0;
    rand_payloads();
    model_reset();

    // reset hold with in0_val asserted
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
      chk("rst_in0_rdy", MW'(in0_rdy), '0);
    end
    reset = 1'b1;
    in0_val = 1'b0;
    check_all();
    tick();
    chk("rdy_after_release", MW'(in0_rdy), MW'(1));

    // single message in domain 0 slot
    in0_val = 1'b1;
    in0_msg_control = CN'(12'h0A5);
    in0_msg_data = 32'hDEADBEEF;
    out_rdy = 1'b1;
    tick();
    in0_val = 1'b0;
    chk("single_val", MW'(out_val), MW'(1));
    chk("single_ctrl", MW'(out_msg_control), MW'(12'h0A5));
    chk("single_data", MW'(out_msg_data), MW'(32'hDEADBEEF));
    chk("single_dom", MW'(out_domain), '0);
    tick();
    chk("single_popped", MW'(out_val), '0);

    // TDM isolation, with domain 0 idle then flooding
    for (int flood = 0; flood < 2; flood++) begin
      do_reset();
      rand_payloads();
      seen = {in1_msg_control, in1_msg_data};
      in1_val = 1'b1;
      in0_val = (flood == 1);
      out_rdy = 1'b1;
      tick();
      in1_val = 1'b0;
      while (n_edges < 4) begin
        rand_payloads();
        tick();
      end
      in0_val = 1'b0;
      chk("iso_val", MW'(out_val), MW'(1));
      chk("iso_dom", MW'(out_domain), MW'(1));
      chk("iso_msg", {out_msg_control, out_msg_data}, seen);
    end

    // backpressure across the slot boundary
    do_reset();
    rand_payloads();
    seen = {in0_msg_control, in0_msg_data};
    in0_val = 1'b1;
    tick();
    in0_val = 1'b0;
    while (n_edges < 8) tick();
    chk("bp_val", MW'(out_val), MW'(1));
    chk("bp_msg", {out_msg_control, out_msg_data}, seen);
    out_rdy = 1'b1;
    tick();
    chk("bp_popped", MW'(out_val), '0);

    // full queue on domain 1
    do_reset();
    out_rdy = 1'b0;
    in1_val = 1'b1;
    rand_payloads();
    tick();
    rand_payloads();
    tick();
    chk("full_rdy", MW'(in1_rdy), '0);
    rand_payloads();
    while (n_edges < 8) begin
      out_rdy = (n_edges >= 4);
      if (in1_rdy === 1'b1) begin
        tick();
        in1_val = 1'b0;
      end else begin
        tick();
      end
    end
    in1_val = 1'b0;

    // asynchronous reset with both queues full
    do_reset();
    in0_val = 1'b1;
    in1_val = 1'b1;
    out_rdy = 1'b0;
    repeat (3) begin
      rand_payloads();
      tick();
    end
    in0_val = 1'b0;
    in1_val = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_val", MW'(out_val), '0);
    chk("arst_in0_rdy", MW'(in0_rdy), '0);
    chk("arst_in1_rdy", MW'(in1_rdy), '0);
    chk("arst_dom", MW'(out_domain), '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_all();
    tick();
    tick();

    // random traffic
    do_reset();
    repeat (600) begin
      rand_payloads();
      in0_val = ($urandom_range(0, 3) != 0);
      in1_val = ($urandom_range(0, 2) == 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/net_tdm_ingress.md
Name: net_tdm_ingress

Overview:
- Injection stage directly upstream of each ring terminal input port (in_val/in_rdy/in_msg_control/in_msg_data).
- Buffers traffic from two security domains (domain 0 = d1, domain 1 = d2) in separate queues.
- Forwards them onto the single terminal port under fixed time-division multiplexing, so one domain's traffic never changes when the other domain gets service.
- Also drives a domain tag used by the downstream router/demux.

Parameters:
- p_msg_cnbits, 44: control message width (VC_NET_MSG_NBITS of pc/o/s).
- p_msg_dnbits, 32: data payload width.
- p_num_entries, 2: queue depth per domain; power of two, >= 2.
- p_slot_cycles, 4: cycles per TDM slot; >= 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in0_val  in  1  domain-0 message valid.
- in0_rdy  out  1  domain-0 queue can accept.
- in0_msg_control  in  p_msg_cnbits  domain-0 control message.
- in0_msg_data  in  p_msg_dnbits  domain-0 data payload.
- in1_val / in1_rdy / in1_msg_control / in1_msg_data: same as in0_*, for domain 1.
- out_val  out  1  message valid toward ring terminal port.
- out_rdy  in  1  ring terminal port accepts.
- out_msg_control  out  p_msg_cnbits  head control message of active domain.
- out_msg_data  out  p_msg_dnbits  head data payload of active domain.
- out_domain  out  1  active slot domain (0/1).

Behaviour:
- Reset asserted (reset==0), asynchronously:
  - both queues empty; slot counter = 0; active domain = 0.
  - out_val = 0, out_domain = 0, in0_rdy = in1_rdy = 0.
  - out_msg_* = 0 is not required (don't-care while out_val = 0).
- First rising edge after reset deasserts: in*_rdy = 1.
- Enqueue: inK_val & inK_rdy on an edge writes control+data into queue K.
  - inK_rdy = !fullK. It is registered-state only, with no combinational path from out_rdy or the other domain.
- Slot counter: 0..p_slot_cycles-1, increments every cycle.
  - On wrap to 0, active domain toggles.
  - Slot sequence depends only on time since reset, never on queue state or handshakes. No work-conserving steal: an empty active queue leaves the port idle.
- Output:
  - out_val = !empty[active]; out_msg_* = head of queue[active]; out_domain = active.
- Dequeue: out_val & out_rdy on an edge pops head of queue[active].
- Latency: a message enqueued at edge t is visible no earlier than cycle t+1. There is no bypass when the queue is empty.
- Full queue with simultaneous dequeue: inK_rdy stays 0 that cycle. No same-cycle refill through a full queue.
- Empty queue with simultaneous enqueue: the entry is written; out_val rises next cycle if its domain is active.
- Slot boundary while out_val & !out_rdy: the head is retained and not popped. out_val/msg switch to the other domain next cycle.
  - Downstream must not assume val persistence across a slot boundary; the ring router input accepts combinationally.
- Queue pointers are log2(p_num_entries) bits plus one wrap bit. Full = addresses equal and wrap bits differ. Pointers wrap naturally.
- p_slot_cycles == 1: domain alternates every cycle.
- Reset mid-operation: queued messages are discarded. No partial message is emitted.

Decomposition:
- Shared package / header:
  - domain encoding constants (DOMAIN_D1=0, DOMAIN_D2=1).
  - existing VC_NET_MSG_NBITS / field macros.
  - clog2 helper.
- Sub-module net_tdm_ingress_queue (one per domain):
  - parameterised depth/width, enq val/rdy, deq val/rdy.
  - same asynchronous active-low reset.
- Top level holds the slot counter, active-domain register and output mux.

Test Plan:
- Reset hold:
  - Stimulus: reset=0 for 3 cycles with in0_val=1.
  - Response: out_val=0, in0_rdy=0, out_domain=0 throughout. in0_rdy=1 on the first cycle after release.
- Single message, slot 0:
  - Stimulus: enqueue in0 control=0x0A5, data=0xDEADBEEF at cycle 1, out_rdy=1.
  - Response: out_val=1 at cycle 2 with the same control/data, out_domain=0. Popped at that edge; out_val=0 at cycle 3.
- TDM isolation:
  - Stimulus: p_slot_cycles=4; domain 1 enqueues at cycle 0; domain 0 stays idle.
  - Response: out_val stays 0 during cycles 0-3. Domain-1 message appears at cycle 4 with out_domain=1. Timing is identical whether or not domain 0 floods its queue.
- Backpressure across boundary:
  - Stimulus: domain 0 holds 1 message, out_rdy=0 through cycles 0-3.
  - Response: message is not lost. out_val=0 in cycles 4-7; the message reappears at cycle 8 and pops when out_rdy=1.
- Full queue:
  - Stimulus: p_num_entries=2, three back-to-back in1 enqueues with out_rdy=0.
  - Response: in1_rdy=0 after the 2nd accept. The 3rd is accepted only after a dequeue edge. Ordering is preserved: 1,2,3.
- Async reset mid-flight:
  - Stimulus: both queues hold 2 entries, reset pulses low between clock edges.
  - Response: out_val=0 immediately without waiting for a clock edge. Queues are empty after release; slot counter restarts at domain 0.
